// File: rtl/nes_poll_scheduler.sv
// nes_poll_scheduler: frame-rate poll sequencer for NUM_PADS nes_decoder
// instances, reading pads in order with per-wait timeouts and overrun flag.
module nes_poll_scheduler #(
   parameter  int NUM_PADS = 2,
   parameter  int POLL_DIV = 50000,
   parameter  int TIMEOUT  = 255,
   localparam int IW       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic                in_clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [NUM_PADS-1:0] ready_to_read,
   output logic [NUM_PADS-1:0] read_data,
   output logic [IW-1:0]       cur_pad,
   output logic                busy,
   output logic                frame_done,
   output logic [NUM_PADS-1:0] timeout_err,
   output logic                overrun,
   input  logic                clear_err
);

   localparam int TW = $clog2(POLL_DIV);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TICK_MAX = TW'(POLL_DIV - 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_PAD = IW'(NUM_PADS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRDY,
      S_PULSE,
      S_WACK,
      S_WDONE,
      S_NEXT
   } state_t;

   state_t              state_q, state_d;
   logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
   logic [WW-1:0]       wait_q, wait_d;
   logic [IW-1:0]       cur_pad_q, cur_pad_d;
   logic [NUM_PADS-1:0] read_data_q, read_data_d;
   logic [NUM_PADS-1:0] timeout_err_q, timeout_err_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                overrun_q, overrun_d;

   logic tick;
   logic rdy_sel;
   logic waiting;
   logic expired;
   logic to_set;

   // Select the ready line of the pad currently being serviced.
   always_comb begin
      rdy_sel = 1'b0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (cur_pad_q == IW'(i)) rdy_sel = ready_to_read[i];
      end
   end

   // Frame tick divider, sequencing FSM, wait timer and error flags.
   always_comb begin
      tick = enable && (tick_cnt_q == '0);
      tick_cnt_d = tick_cnt_q;
      if (enable) begin
         tick_cnt_d = (tick_cnt_q == '0) ? TICK_MAX : tick_cnt_q - 1'b1;
      end

      state_d      = state_q;
      cur_pad_d    = cur_pad_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      to_set       = 1'b0;
      expired      = (wait_q == WAIT_MAX);

      // Clear first so that a same-cycle set event wins.
      timeout_err_d = clear_err ? '0 : timeout_err_q;
      overrun_d     = clear_err ? 1'b0 : overrun_q;
      if (tick && state_q != S_IDLE) overrun_d = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d   = S_WRDY;
               cur_pad_d = '0;
               busy_d    = 1'b1;
            end
         end
         S_WRDY: begin
            if (rdy_sel) state_d = S_PULSE;
            else if (expired) begin
               to_set  = 1'b1;
               state_d = S_NEXT;
            end
         end
         S_PULSE: state_d = S_WACK;
         S_WACK: begin
            if (!rdy_sel) state_d = S_WDONE;
            else if (expired) begin
               to_set  = 1'b1;
               state_d = S_NEXT;
            end
         end
         S_WDONE: begin
            if (rdy_sel) state_d = S_NEXT;
            else if (expired) begin
               to_set  = 1'b1;
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (cur_pad_q == LAST_PAD) begin
               state_d      = S_IDLE;
               busy_d       = 1'b0;
               frame_done_d = 1'b1;
            end else begin
               state_d   = S_WRDY;
               cur_pad_d = cur_pad_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      for (int i = 0; i < NUM_PADS; i++) begin
         if (to_set && cur_pad_q == IW'(i)) timeout_err_d[i] = 1'b1;
      end

      // Timer restarts on every state change and only runs while waiting.
      waiting = (state_q == S_WRDY) || (state_q == S_WACK) ||
                (state_q == S_WDONE);
      wait_d = '0;
      if (waiting && state_d == state_q) wait_d = wait_q + 1'b1;

      read_data_d = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         read_data_d[i] = (state_d == S_PULSE) && (cur_pad_d == IW'(i));
      end
   end

   // State and registered outputs; reset overrides everything.
   always_ff @(posedge in_clock) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         tick_cnt_q    <= TICK_MAX;
         wait_q        <= '0;
         cur_pad_q     <= '0;
         read_data_q   <= '0;
         timeout_err_q <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         tick_cnt_q    <= tick_cnt_d;
         wait_q        <= wait_d;
         cur_pad_q     <= cur_pad_d;
         read_data_q   <= read_data_d;
         timeout_err_q <= timeout_err_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         overrun_q     <= overrun_d;
      end
   end

   assign read_data   = read_data_q;
   assign cur_pad     = cur_pad_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign timeout_err = timeout_err_q;
   assign overrun     = overrun_q;

endmodule
